mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-requester arbiter that shares one single-beat memory port between the core's instruction-fetch bus and data bus. It sits between the core's `ireq`/`iresp` and `dreq`/`dresp` endpoints and the memory-side bus. It serialises one transaction at a time. Data accesses win by default; a bounded-starvation counter guarantees fetch progress.

## Interface

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before one fetch grant is forced (range 1..15).

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- i_valid  in  1  fetch request pending; held until i_data_ok.
- i_addr  in  64  fetch byte address (4-byte aligned).
- i_data_ok  out  1  one-cycle pulse, fetch complete.
- i_data  out  32  fetched instruction, valid with i_data_ok.
- d_valid  in  1  data request pending; held until d_data_ok.
- d_addr  in  64  data byte address.
- d_size  in  3  access size code (0=1B, 1=2B, 2=4B, 3=8B).
- d_strobe  in  8  byte-write enables; all zero means read.
- d_wdata  in  64  write data.
- d_data_ok  out  1  one-cycle pulse, data access complete.
- d_rdata  out  64  read data, valid with d_data_ok.
- m_valid  out  1  memory request valid.
- m_write  out  1  1 = write.
- m_addr  out  64  memory address.
- m_size  out  3  access size.
- m_strobe  out  8  byte enables.
- m_wdata  out  64  write data.
- m_ready  in  1  memory completes the current request this cycle.
- m_rdata  in  64  read data, valid with m_ready.
- busy  out  1  state is not IDLE.

## Operation

- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - Only d_valid asserted: go to BUSY_D.
  - Only i_valid asserted: go to BUSY_I.
  - Both asserted: go to BUSY_D, unless starve_cnt == STARVE_LIMIT, in which case go to BUSY_I.
- On the grant edge, latch the winner's request into holding registers. The m_* outputs drive only from these registers. This keeps them stable even if the requester changes its inputs.
- Fetch request mapping:
  - m_write=0, m_size=3'b010, m_strobe=0, m_wdata=0.
  - m_addr = i_addr.
- Data request mapping:
  - m_write = |d_strobe.
  - m_addr, m_size, m_strobe and m_wdata pass through from the latched d_* values.
- BUSY_x: m_valid=1. On m_ready, latch m_rdata and go to RESP_x.
- RESP_x: assert x_data_ok=1 for exactly one cycle, then go to IDLE. No grant is issued in a RESP cycle.
- i_data = latched_rdata[31:0] when latched addr[2]==0, otherwise latched_rdata[63:32].
- d_rdata = latched_rdata (unshifted; extension is done by the core).
- starve_cnt (4-bit) update on each grant:
  - Data grant while i_valid=1: increment, saturating at STARVE_LIMIT.
  - Any fetch grant: clear to 0.
  - Data grant with i_valid=0: clear to 0.
- Outside their RESP cycle, i_data_ok and d_data_ok are 0. i_data and d_rdata hold their last value.

## Timing

- Reset (async assert, any state):
  - State goes to IDLE and starve_cnt to 0.
  - m_valid, m_write, m_strobe, m_addr, m_size, m_wdata, i_data_ok, d_data_ok, busy, i_data and d_rdata all go to 0 immediately.
  - An in-flight memory request is abandoned; no data_ok is issued for it.
  - Deassertion is sampled synchronously; the first grant can occur on the first rising edge after release.
- Latency with request at edge t and m_ready at the first BUSY cycle:
  - m_valid is high in cycle t+1.
  - data_ok is high in cycle t+2.
  - busy falls at t+3.
- Back-to-back throughput: one transaction per 3 cycles minimum.
- m_ready sampled while not in BUSY_x is ignored.
- The m_* outputs are constant for the whole BUSY_x interval.
- A requester dropping valid mid-transaction does not cancel it; its data_ok still pulses.

## Test plan

- Fetch only:
  - Stimulus: i_addr=0x8000_0004; memory returns m_rdata=0x1111_2222_3333_4444 after 2 BUSY cycles.
  - Required: m_size=2 and m_write=0 during BUSY; i_data_ok pulses once with i_data=0x1111_2222; d_data_ok stays 0.
- Data write:
  - Stimulus: d_addr=0x8000_0100, d_strobe=0x0F, d_wdata=0xDEAD_BEEF.
  - Required: m_write=1, m_strobe=0x0F, m_wdata=0xDEAD_BEEF held stable until m_ready; d_data_ok is a single pulse.
- Simultaneous requests with STARVE_LIMIT=4:
  - Stimulus: i_valid and d_valid held continuously, m_ready=1 every BUSY cycle.
  - Required: grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each fetch grant.
- Input change mid-flight:
  - Stimulus: change d_addr and drop d_valid during BUSY_D.
  - Required: m_addr keeps the latched value; d_data_ok still pulses.
- Reset mid-operation:
  - Stimulus: assert reset in BUSY_D before m_ready arrives.
  - Required: m_valid and busy go to 0 asynchronously, no d_data_ok is ever issued, and a new fetch after release is granted normally.
- Stray m_ready:
  - Stimulus: m_ready=1 while IDLE.
  - Required: no state change and no data_ok pulse.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter: shares one single-beat memory port between the fetch and data buses.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [63:0] i_addr,
    output logic        i_data_ok,
    output logic [31:0] i_data,
    input  logic        d_valid,
    input  logic [63:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [7:0]  d_strobe,
    input  logic [63:0] d_wdata,
    output logic        d_data_ok,
    output logic [63:0] d_rdata,
    output logic        m_valid,
    output logic        m_write,
    output logic [63:0] m_addr,
    output logic [2:0]  m_size,
    output logic [7:0]  m_strobe,
    output logic [63:0] m_wdata,
    input  logic        m_ready,
    input  logic [63:0] m_rdata,
    output logic        busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             gnt_i, gnt_d;
    logic             i_data_ok_q, d_data_ok_q, busy_q;
    logic             m_valid_q, m_write_q;
    logic [63:0]      m_addr_q, m_wdata_q, d_rdata_q;
    logic [2:0]       m_size_q;
    logic [7:0]       m_strobe_q;
    logic [31:0]      i_data_q;

    // Grant decision and starvation counter update; grants only happen from IDLE.
    always_comb begin
        gnt_i    = 1'b0;
        gnt_d    = 1'b0;
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (d_valid && !(i_valid && (starve_q == LIMIT))) begin
                gnt_d = 1'b1;
            end else if (i_valid) begin
                gnt_i = 1'b1;
            end
        end
        if (gnt_i) begin
            starve_d = '0;
        end else if (gnt_d) begin
            if (!i_valid) begin
                starve_d = '0;
            end else if (starve_q != LIMIT) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            i_data_ok_q <= 1'b0;
            d_data_ok_q <= 1'b0;
            busy_q      <= 1'b0;
            m_valid_q   <= 1'b0;
            m_write_q   <= 1'b0;
            m_addr_q    <= '0;
            m_size_q    <= '0;
            m_strobe_q  <= '0;
            m_wdata_q   <= '0;
            i_data_q    <= '0;
            d_rdata_q   <= '0;
        end else begin
            starve_q    <= starve_d;
            i_data_ok_q <= 1'b0;
            d_data_ok_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The winner's request is captured here; m_* never follow the live inputs.
                    if (gnt_d) begin
                        state_q    <= BUSY_D;
                        busy_q     <= 1'b1;
                        m_valid_q  <= 1'b1;
                        m_write_q  <= |d_strobe;
                        m_addr_q   <= d_addr;
                        m_size_q   <= d_size;
                        m_strobe_q <= d_strobe;
                        m_wdata_q  <= d_wdata;
                    end else if (gnt_i) begin
                        state_q    <= BUSY_I;
                        busy_q     <= 1'b1;
                        m_valid_q  <= 1'b1;
                        m_write_q  <= 1'b0;
                        m_addr_q   <= i_addr;
                        m_size_q   <= 3'b010;
                        m_strobe_q <= '0;
                        m_wdata_q  <= '0;
                    end
                end
                BUSY_I: begin
                    if (m_ready) begin
                        state_q     <= RESP_I;
                        m_valid_q   <= 1'b0;
                        i_data_ok_q <= 1'b1;
                        i_data_q    <= m_addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
                    end
                end
                BUSY_D: begin
                    if (m_ready) begin
                        state_q     <= RESP_D;
                        m_valid_q   <= 1'b0;
                        d_data_ok_q <= 1'b1;
                        d_rdata_q   <= m_rdata;
                    end
                end
                RESP_I, RESP_D: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign i_data_ok = i_data_ok_q;
    assign d_data_ok = d_data_ok_q;
    assign i_data    = i_data_q;
    assign d_rdata   = d_rdata_q;
    assign m_valid   = m_valid_q;
    assign m_write   = m_write_q;
    assign m_addr    = m_addr_q;
    assign m_size    = m_size_q;
    assign m_strobe  = m_strobe_q;
    assign m_wdata   = m_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized run against a request-level model.
module tb_mem_bus_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, d_valid, m_ready;
    logic [63:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic        i_data_ok, d_data_ok, m_valid, m_write, busy;
    logic [31:0] i_data;
    logic [63:0] d_rdata, m_addr, m_wdata;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int n_iok    = 0;
    int n_dok    = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_data(i_data),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_size(m_size),
        .m_strobe(m_strobe), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (i_data_ok) n_iok++;
        if (d_data_ok) n_dok++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid = 0; d_valid = 0; m_ready = 0;
        i_addr = '0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0; m_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        #3;
        tot_cnt++; if ({m_valid, m_write, busy, i_data_ok, d_data_ok} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {m_valid, m_write, busy, i_data_ok, d_data_ok}); else pass_cnt++;
        tot_cnt++; if ({m_addr, m_wdata, m_size, m_strobe} !== '0)
            $display("FAIL reset_mbus: got addr=%h wdata=%h size=%0d strb=%h want 0", m_addr, m_wdata, m_size, m_strobe); else pass_cnt++;
        tot_cnt++; if ({i_data, d_rdata} !== '0)
            $display("FAIL reset_rdata: got i=%h d=%h want 0", i_data, d_rdata); else pass_cnt++;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch_only();
        int i0 = n_iok, d0 = n_dok;
        i_addr = 64'h8000_0004; i_valid = 1;
        tick();
        for (int c = 0; c < 2; c++) begin
            tot_cnt++; if (m_valid !== 1 || m_size !== 3'd2 || m_write !== 0 || m_addr !== 64'h8000_0004)
                $display("FAIL fetch_busy%0d: got v=%b sz=%0d w=%b a=%h want 1/2/0/80000004", c, m_valid, m_size, m_write, m_addr);
            else pass_cnt++;
            if (c == 1) begin m_ready = 1; m_rdata = 64'h1111_2222_3333_4444; end
            tick();
        end
        m_ready = 0;
        tot_cnt++; if (i_data_ok !== 1 || i_data !== 32'h1111_2222)
            $display("FAIL fetch_resp: got ok=%b data=%h want 1/11112222", i_data_ok, i_data); else pass_cnt++;
        i_valid = 0;
        tick();
        tot_cnt++; if (busy !== 0 || i_data_ok !== 0)
            $display("FAIL fetch_done: got busy=%b ok=%b want 0/0", busy, i_data_ok); else pass_cnt++;
        tick();
        tot_cnt++; if (n_iok - i0 != 1 || n_dok - d0 != 0)
            $display("FAIL fetch_pulses: got i=%0d d=%0d want 1/0", n_iok - i0, n_dok - d0); else pass_cnt++;
    endtask

    task automatic test_data_write();
        int i0 = n_iok, d0 = n_dok;
        d_addr = 64'h8000_0100; d_strobe = 8'h0F; d_wdata = 64'hDEAD_BEEF; d_size = 3'd2; d_valid = 1;
        tick();
        for (int c = 0; c < 3; c++) begin
            tot_cnt++; if (m_valid !== 1 || m_write !== 1 || m_strobe !== 8'h0F || m_wdata !== 64'hDEAD_BEEF || m_addr !== 64'h8000_0100)
                $display("FAIL write_busy%0d: got v=%b w=%b s=%h d=%h a=%h want 1/1/0f/deadbeef/80000100", c, m_valid, m_write, m_strobe, m_wdata, m_addr);
            else pass_cnt++;
            if (c == 2) begin m_ready = 1; m_rdata = {$urandom, $urandom}; end
            tick();
        end
        m_ready = 0;
        tot_cnt++; if (d_data_ok !== 1)
            $display("FAIL write_resp: got ok=%b want 1", d_data_ok); else pass_cnt++;
        d_valid = 0;
        tick(); tick();
        tot_cnt++; if (n_dok - d0 != 1 || n_iok - i0 != 0)
            $display("FAIL write_pulses: got d=%0d i=%0d want 1/0", n_dok - d0, n_iok - i0); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int order[$];
        int when[$];
        int w = 0;
        int cyc = 0;
        reset = 0; tick(); reset = 1; tick();
        i_addr = 64'h1000; d_addr = 64'h2000; d_strobe = 0; d_size = 3'd3;
        i_valid = 1; d_valid = 1; m_ready = 1;
        while (order.size() < 10 && cyc < 60) begin
            tick(); cyc++;
            if (i_data_ok) begin order.push_back(1); when.push_back(cyc); end
            if (d_data_ok) begin order.push_back(0); when.push_back(cyc); end
        end
        idle_inputs();
        tot_cnt++; if (order.size() != 10)
            $display("FAIL sim_count: got %0d grants want 10", order.size()); else pass_cnt++;
        for (int k = 0; k < order.size() && k < 10; k++) begin
            int exp_i;
            exp_i = (w == LIMIT) ? 1 : 0;
            w = exp_i ? 0 : w + 1;
            tot_cnt++; if (order[k] != exp_i)
                $display("FAIL sim_order%0d: got %s want %s", k, order[k] ? "I" : "D", exp_i ? "I" : "D"); else pass_cnt++;
        end
        if (when.size() == 10) begin
            tot_cnt++; if (when[9] - when[0] != 27)
                $display("FAIL sim_throughput: got %0d cycles want 27", when[9] - when[0]); else pass_cnt++;
        end
        tick(); tick();
    endtask

    task automatic test_midflight();
        logic [63:0] a, wd, rd;
        a = {32'h8000_0000, $urandom} & ~64'h7; wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
        d_addr = a; d_wdata = wd; d_strobe = 8'hFF; d_size = 3'd3; d_valid = 1;
        tick();
        d_addr = ~a; d_wdata = '0; d_strobe = 8'h01; d_valid = 0;
        for (int c = 0; c < 2; c++) begin
            tot_cnt++; if (m_valid !== 1 || m_addr !== a || m_wdata !== wd || m_strobe !== 8'hFF)
                $display("FAIL mid_busy%0d: got v=%b a=%h d=%h s=%h want 1/%h/%h/ff", c, m_valid, m_addr, m_wdata, m_strobe, a, wd);
            else pass_cnt++;
            if (c == 1) begin m_ready = 1; m_rdata = rd; end
            tick();
        end
        m_ready = 0;
        tot_cnt++; if (d_data_ok !== 1 || d_rdata !== rd)
            $display("FAIL mid_resp: got ok=%b data=%h want 1/%h", d_data_ok, d_rdata, rd); else pass_cnt++;
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        int d0 = n_dok;
        logic [63:0] a, rd;
        d_addr = 64'h8000_0200; d_strobe = 8'h00; d_valid = 1;
        tick();
        tot_cnt++; if (m_valid !== 1 || busy !== 1)
            $display("FAIL rmid_pre: got v=%b busy=%b want 1/1", m_valid, busy); else pass_cnt++;
        #2 reset = 0;
        #1;
        tot_cnt++; if (m_valid !== 0 || busy !== 0)
            $display("FAIL rmid_async: got v=%b busy=%b want 0/0", m_valid, busy); else pass_cnt++;
        d_valid = 0; m_ready = 1;
        tick(); tick();
        reset = 1; m_ready = 0;
        tick(); tick();
        tot_cnt++; if (n_dok != d0 || busy !== 0)
            $display("FAIL rmid_noresp: got pulses=%0d busy=%b want 0/0", n_dok - d0, busy); else pass_cnt++;
        a = {32'h0, $urandom} & ~64'h7; rd = {$urandom, $urandom};
        i_addr = a; i_valid = 1;
        tick();
        tot_cnt++; if (m_valid !== 1 || m_addr !== a || m_write !== 0)
            $display("FAIL rmid_fetch: got v=%b a=%h w=%b want 1/%h/0", m_valid, m_addr, m_write, a); else pass_cnt++;
        m_ready = 1; m_rdata = rd;
        tick();
        tot_cnt++; if (i_data_ok !== 1 || i_data !== rd[31:0])
            $display("FAIL rmid_fdata: got ok=%b data=%h want 1/%h", i_data_ok, i_data, rd[31:0]); else pass_cnt++;
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_stray_ready();
        int i0 = n_iok, d0 = n_dok;
        m_ready = 1; m_rdata = {$urandom, $urandom};
        for (int c = 0; c < 3; c++) begin
            tick();
            tot_cnt++; if (busy !== 0 || m_valid !== 0)
                $display("FAIL stray%0d: got busy=%b v=%b want 0/0", c, busy, m_valid); else pass_cnt++;
        end
        m_ready = 0;
        tick();
        tot_cnt++; if (n_iok != i0 || n_dok != d0)
            $display("FAIL stray_pulses: got i=%0d d=%0d want 0/0", n_iok - i0, n_dok - d0); else pass_cnt++;
    endtask

    // Randomized traffic: the model tracks pending requests, how long a fetch has waited, and the payloads.
    task automatic test_random();
        bit          ip = 0, dp = 0, win_d;
        int          waited = 0;
        int          cyc;
        logic [63:0] rd;
        for (int it = 0; it < 40; it++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1; i_addr = {32'h8000_0000, $urandom} & ~64'h3;
            end
            if (!dp && (!ip || $urandom_range(0, 1) == 1)) begin
                dp = 1; d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
                d_size = 3'($urandom_range(0, 3));
                d_strobe = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            end
            i_valid = ip; d_valid = dp;
            cyc = 0;
            do begin tick(); cyc++; end while (!m_valid && cyc < 10);
            tot_cnt++; if (m_valid !== 1) begin
                $display("FAIL rnd_timeout%0d: got m_valid=%b want 1", it, m_valid);
                idle_inputs();
                return;
            end else pass_cnt++;
            win_d = dp && !(ip && waited == LIMIT);
            if (win_d) waited = ip ? ((waited < LIMIT) ? waited + 1 : waited) : 0;
            else waited = 0;
            tot_cnt++;
            if (win_d) begin
                if (m_addr !== d_addr || m_write !== (|d_strobe) || m_size !== d_size || m_strobe !== d_strobe || m_wdata !== d_wdata)
                    $display("FAIL rnd_dreq%0d: got a=%h w=%b sz=%0d s=%h d=%h want %h/%b/%0d/%h/%h", it,
                             m_addr, m_write, m_size, m_strobe, m_wdata, d_addr, |d_strobe, d_size, d_strobe, d_wdata);
                else pass_cnt++;
            end else begin
                if (m_addr !== i_addr || m_write !== 0 || m_size !== 3'd2 || m_strobe !== 0 || m_wdata !== 0)
                    $display("FAIL rnd_ireq%0d: got a=%h w=%b sz=%0d s=%h d=%h want %h/0/2/00/0", it,
                             m_addr, m_write, m_size, m_strobe, m_wdata, i_addr);
                else pass_cnt++;
            end
            repeat ($urandom_range(0, 2)) tick();
            rd = {$urandom, $urandom};
            m_ready = 1; m_rdata = rd;
            tick();
            m_ready = 0;
            tot_cnt++;
            if (win_d) begin
                if (d_data_ok !== 1 || i_data_ok !== 0 || d_rdata !== rd)
                    $display("FAIL rnd_dresp%0d: got dok=%b iok=%b data=%h want 1/0/%h", it, d_data_ok, i_data_ok, d_rdata, rd);
                else pass_cnt++;
                dp = 0; d_valid = 0;
            end else begin
                if (i_data_ok !== 1 || d_data_ok !== 0 || i_data !== (i_addr[2] ? rd[63:32] : rd[31:0]))
                    $display("FAIL rnd_iresp%0d: got iok=%b dok=%b data=%h want 1/0/%h", it, i_data_ok, d_data_ok, i_data,
                             i_addr[2] ? rd[63:32] : rd[31:0]);
                else pass_cnt++;
                ip = 0; i_valid = 0;
            end
        end
        idle_inputs();
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_data_write();
        test_simultaneous();
        test_midflight();
        test_reset_mid();
        test_stray_ready();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
